// File: rtl/llr_stream_tx_pkg.sv
// Shared chunking constants, FSM encodings and sizing helpers for the LLR
// stream transmitter and the decoder-side loader.
package llr_stream_tx_pkg;

  localparam logic RESET_VAL = 1'b0;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_N_LLRS     = 4;
  localparam int DEF_N_V        = 31;
  localparam int DEF_GAP_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2
  } tx_state_t;

  function automatic int n_beats(input int nv, input int nl);
    return (nv + nl - 1) / nl;
  endfunction

  function automatic int last_llrs(input int nv, input int nl);
    return (nv - 1) % nl + 1;
  endfunction

  // Counter must reach both the last beat index and the gap length.
  function automatic int cnt_width(input int nb, input int gap);
    int m;
    m = (nb > gap) ? nb : gap;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/llr_beat_mux.sv
// Combinational selector of beat k from a frame: full beats are MS-first
// from the top of the frame, the last beat is low-aligned and zero-filled.
module llr_beat_mux
  import llr_stream_tx_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int N_LLRS = DEF_N_LLRS,
  parameter int N_V    = DEF_N_V,
  parameter int BW     = 4
) (
  input  logic [N_V*WIDTH-1:0]    frame,
  input  logic [BW-1:0]           beat,
  output logic [N_LLRS*WIDTH-1:0] llr
);

  localparam int NB = n_beats(N_V, N_LLRS);
  localparam int LL = last_llrs(N_V, N_LLRS);
  localparam int IW = (N_V > 1) ? $clog2(N_V) : 1;

  logic [WIDTH-1:0] llrs [N_V];
  logic [WIDTH-1:0] slot [N_LLRS];
  logic             is_last;

  assign is_last = (int'(beat) == NB - 1);

  for (genvar gi = 0; gi < N_V; gi++) begin : g_split
    assign llrs[gi] = frame[gi*WIDTH +: WIDTH];
  end

  for (genvar gi = 0; gi < N_LLRS; gi++) begin : g_slot
    always_comb begin
      int idx;
      slot[gi] = '0;
      idx = is_last ? gi : (N_V - (int'(beat) + 1) * N_LLRS + gi);
      if (idx >= 0 && idx < N_V && (!is_last || gi < LL))
        slot[gi] = llrs[IW'(idx)];
    end
    assign llr[gi*WIDTH +: WIDTH] = slot[gi];
  end

endmodule

// File: rtl/llr_stream_tx.sv
// Frame-to-chunk serializer feeding the decoder LLR load bus, with a
// one-frame pending buffer and a forced idle gap between frames.
module llr_stream_tx
  import llr_stream_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int N_LLRS     = DEF_N_LLRS,
  parameter int N_V        = DEF_N_V,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH*N_V-1:0]    frame_in,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic                    hold,
  output logic [N_LLRS*WIDTH-1:0] llr,
  output logic                    first_data,
  output logic                    data_valid,
  output logic                    busy
);

  localparam int NB = n_beats(N_V, N_LLRS);
  localparam int CW = cnt_width(NB, GAP_CYCLES);

  tx_state_t               state_reg;
  logic                    pend_valid_reg;
  logic [N_V*WIDTH-1:0]    pend_reg;
  logic [N_V*WIDTH-1:0]    active_reg;
  logic [CW-1:0]           cnt_reg;
  logic [N_LLRS*WIDTH-1:0] llr_reg;
  logic                    first_reg;
  logic                    dv_reg;

  logic [N_V*WIDTH-1:0]    mux_frame;
  logic [CW-1:0]           mux_beat;
  logic [N_LLRS*WIDTH-1:0] mux_llr;

  // Beat 0 is taken straight from pending on the edge it moves to active.
  assign mux_frame = (state_reg == ST_IDLE) ? pend_reg : active_reg;
  assign mux_beat  = (state_reg == ST_IDLE) ? '0 : cnt_reg;

  llr_beat_mux #(
    .WIDTH (WIDTH),
    .N_LLRS(N_LLRS),
    .N_V   (N_V),
    .BW    (CW)
  ) u_mux (
    .frame(mux_frame),
    .beat (mux_beat),
    .llr  (mux_llr)
  );

  always_ff @(posedge clk) begin
    if (rst == RESET_VAL) begin
      state_reg      <= ST_IDLE;
      pend_valid_reg <= 1'b0;
      cnt_reg        <= '0;
      llr_reg        <= '0;
      first_reg      <= 1'b0;
      dv_reg         <= 1'b0;
    end else begin
      first_reg <= 1'b0;
      dv_reg    <= 1'b0;
      if (frame_valid && !pend_valid_reg) begin
        pend_reg       <= frame_in;
        pend_valid_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (pend_valid_reg && !hold) begin
            active_reg     <= pend_reg;
            pend_valid_reg <= 1'b0;
            llr_reg        <= mux_llr;
            first_reg      <= 1'b1;
            dv_reg         <= 1'b1;
            if (NB == 1) begin
              if (GAP_CYCLES == 0) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
              end else begin
                state_reg <= ST_GAP;
                cnt_reg   <= CW'(GAP_CYCLES);
              end
            end else begin
              state_reg <= ST_SEND;
              cnt_reg   <= CW'(1);
            end
          end
        end
        ST_SEND: begin
          if (!hold) begin
            llr_reg <= mux_llr;
            dv_reg  <= 1'b1;
            if (cnt_reg == CW'(NB - 1)) begin
              if (GAP_CYCLES == 0) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
              end else begin
                state_reg <= ST_GAP;
                cnt_reg   <= CW'(GAP_CYCLES);
              end
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        ST_GAP: begin
          if (cnt_reg <= CW'(1)) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign frame_ready = !pend_valid_reg;
  assign busy        = (state_reg != ST_IDLE) || pend_valid_reg;
  assign llr         = llr_reg;
  assign first_data  = first_reg;
  assign data_valid  = dv_reg;

endmodule

// File: tb/tb_llr_stream_tx.sv
// Self-checking bench for llr_stream_tx: table vectors, hold/reset/gap corner
// sequences, randomized frames against a chunking model, and a GAP=0 instance.
module tb_llr_stream_tx;

  localparam int W   = 8;
  localparam int NL  = 4;
  localparam int NV  = 31;
  localparam int GAP = 2;
  localparam int NB  = 8;
  localparam int NV2 = 8;

  typedef struct { logic [31:0] llr; logic first; } vec_t;
  typedef struct { logic [31:0] llr; logic first; int cyc; } obs_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NV*W-1:0]   frame_in;
  logic              frame_valid, frame_ready, hold;
  logic [NL*W-1:0]   llr;
  logic              first_data, data_valid, busy;

  logic [NV2*W-1:0]  frame_in2;
  logic              frame_valid2, frame_ready2, hold2;
  logic [NL*W-1:0]   llr2;
  logic              first_data2, data_valid2, busy2;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic hold_q = 1'b0;
  logic rst_q = 1'b0;
  logic rand_hold = 1'b0;
  int   hs_cyc;
  int   mon_k = 0;
  int   last_end = -1;

  obs_t            obs_q[$];
  obs_t            obs2_q[$];
  logic [NV*W-1:0] sent_q[$];
  logic [31:0]     exp_q[$];
  vec_t            tbl[NB];
  vec_t            tbl2[4];

  llr_stream_tx #(.WIDTH(W), .N_LLRS(NL), .N_V(NV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .hold(hold), .llr(llr), .first_data(first_data),
    .data_valid(data_valid), .busy(busy)
  );

  llr_stream_tx #(.WIDTH(W), .N_LLRS(NL), .N_V(NV2), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .frame_in(frame_in2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready2), .hold(hold2), .llr(llr2), .first_data(first_data2),
    .data_valid(data_valid2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hold_q <= hold;
    rst_q  <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes every valid beat and enforces the hold and inter-frame gap rules.
  always @(negedge clk) begin
    if (!rst_q) begin
      mon_k    = 0;
      last_end = -1;
    end else if (data_valid) begin
      obs_q.push_back('{llr, first_data, cyc});
      chk("hold_rule", {63'd0, hold_q}, 64'd0);
      if (first_data) begin
        mon_k = 0;
        if (last_end >= 0) chk("gap_rule", {63'd0, (cyc - last_end) >= GAP + 1}, 64'd1);
      end
      if (mon_k == NB - 1) last_end = cyc;
      mon_k++;
    end
    if (data_valid2) obs2_q.push_back('{llr2, first_data2, cyc});
  end

  task automatic step();
    @(negedge clk);
    if (rand_hold) hold = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_frame(input logic [NV*W-1:0] f);
    int t;
    t = 0;
    while (!frame_ready && t < 100) begin
      step();
      t++;
    end
    if (!frame_ready) chk("ready_timeout", 64'd0, 64'd1);
    frame_in    = f;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    hs_cyc      = cyc;
    sent_q.push_back(f);
  endtask

  // Reference chunking: walk LLRs from the top index down, N_LLRS per beat,
  // packing the first taken LLR into the most significant position.
  function automatic void push_model(input logic [NV*W-1:0] f);
    int rem, idx, c;
    logic [31:0] v;
    rem = NV;
    idx = NV - 1;
    while (rem > 0) begin
      c = (rem < NL) ? rem : NL;
      v = '0;
      for (int j = 0; j < c; j++) begin
        v = (v << W) | 32'(f[idx*W +: W]);
        idx--;
      end
      exp_q.push_back(v);
      rem -= c;
    end
  endfunction

  task automatic check_table(input string tag);
    chk({tag, "_count"}, obs_q.size(), NB);
    for (int k = 0; k < NB && k < obs_q.size(); k++) begin
      chk({tag, "_llr"}, obs_q[k].llr, tbl[k].llr);
      chk({tag, "_first"}, {63'd0, obs_q[k].first}, {63'd0, tbl[k].first});
    end
  endtask

  task automatic wait_beat(input logic [31:0] v, input string tag);
    int t;
    t = 0;
    while (!(data_valid && llr == v) && t < 40) begin
      step();
      t++;
    end
    chk({tag, "_reached"}, {63'd0, t < 40}, 64'd1);
  endtask

  initial begin
    logic [NV*W-1:0] fdef, frnd;
    int n_exp;

    tbl[0] = '{32'h1F1E1D1C, 1'b1};
    tbl[1] = '{32'h1B1A1918, 1'b0};
    tbl[2] = '{32'h17161514, 1'b0};
    tbl[3] = '{32'h13121110, 1'b0};
    tbl[4] = '{32'h0F0E0D0C, 1'b0};
    tbl[5] = '{32'h0B0A0908, 1'b0};
    tbl[6] = '{32'h07060504, 1'b0};
    tbl[7] = '{32'h00030201, 1'b0};
    tbl2[0] = '{32'h08070605, 1'b1};
    tbl2[1] = '{32'h04030201, 1'b0};
    tbl2[2] = '{32'h18171615, 1'b1};
    tbl2[3] = '{32'h14131211, 1'b0};
    for (int i = 0; i < NV; i++) fdef[i*W +: W] = 8'(i + 1);

    rst = 1'b0; hold = 1'b0; frame_valid = 1'b0; frame_in = '0;
    hold2 = 1'b0; frame_valid2 = 1'b0; frame_in2 = '0;
    repeat (3) step();
    chk("rst_dv", {63'd0, data_valid}, 64'd0);
    chk("rst_first", {63'd0, first_data}, 64'd0);
    chk("rst_llr", llr, 64'd0);
    chk("rst_ready", {63'd0, frame_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    step();

    // single frame, no hold
    obs_q.delete();
    send_frame(fdef);
    repeat (14) step();
    check_table("single");
    for (int k = 0; k < NB && k < obs_q.size(); k++)
      chk("single_cycle", obs_q[k].cyc, hs_cyc + 1 + k);
    chk("single_idle_ready", {63'd0, frame_ready}, 64'd1);
    chk("single_idle_busy", {63'd0, busy}, 64'd0);

    // two frames back-to-back
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < NV; i++) frnd[i*W +: W] = 8'($urandom);
    send_frame(fdef);
    send_frame(frnd);
    repeat (25) step();
    push_model(fdef);
    push_model(frnd);
    chk("b2b_count", obs_q.size(), 2 * NB);
    if (obs_q.size() == 2 * NB) begin
      chk("b2b_first2", {63'd0, obs_q[NB].first}, 64'd1);
      chk("b2b_spacing", obs_q[NB].cyc, obs_q[NB-1].cyc + GAP + 1);
      for (int k = 0; k < 2 * NB; k++) chk("b2b_llr", obs_q[k].llr, exp_q[k]);
    end

    // hold for 3 cycles while beat 4 is on the bus
    obs_q.delete();
    send_frame(fdef);
    wait_beat(tbl[4].llr, "hold");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_dv", {63'd0, data_valid}, 64'd0);
      chk("hold_llr", llr, tbl[4].llr);
    end
    hold = 1'b0;
    repeat (12) step();
    check_table("hold");
    if (obs_q.size() == NB) begin
      chk("hold_resume", obs_q[5].cyc, obs_q[4].cyc + 4);
      chk("hold_span", obs_q[7].cyc, obs_q[0].cyc + 10);
    end

    // reset mid-frame at beat 3
    obs_q.delete();
    send_frame(fdef);
    wait_beat(tbl[3].llr, "rstmid");
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rstmid_dv", {63'd0, data_valid}, 64'd0);
    chk("rstmid_first", {63'd0, first_data}, 64'd0);
    chk("rstmid_llr", llr, 64'd0);
    chk("rstmid_ready", {63'd0, frame_ready}, 64'd1);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    obs_q.delete();
    send_frame(fdef);
    repeat (14) step();
    check_table("after_rst");

    // randomized frames and hold against the model
    obs_q.delete(); exp_q.delete(); sent_q.delete();
    rand_hold = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NV; i++) frnd[i*W +: W] = 8'($urandom);
      send_frame(frnd);
      repeat ($urandom_range(0, 15)) step();
    end
    rand_hold = 1'b0;
    hold = 1'b0;
    repeat (60) step();
    foreach (sent_q[i]) push_model(sent_q[i]);
    n_exp = exp_q.size();
    chk("rand_count", obs_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < obs_q.size(); k++) begin
      chk("rand_llr", obs_q[k].llr, exp_q[k]);
      chk("rand_first", {63'd0, obs_q[k].first}, {63'd0, (k % NB) == 0});
    end

    // N_V=8, GAP_CYCLES=0: two frames stream with no gap
    obs2_q.delete();
    for (int i = 0; i < NV2; i++) frame_in2[i*W +: W] = 8'(i + 1);
    frame_valid2 = 1'b1;
    step();
    for (int i = 0; i < NV2; i++) frame_in2[i*W +: W] = 8'(i + 8'h11);
    for (int t = 0; t < 20; t++) begin
      step();
      if (frame_ready2) break;
    end
    step();
    frame_valid2 = 1'b0;
    repeat (10) step();
    chk("gap0_count", obs2_q.size(), 4);
    for (int k = 0; k < 4 && k < obs2_q.size(); k++) begin
      chk("gap0_llr", obs2_q[k].llr, tbl2[k].llr);
      chk("gap0_first", {63'd0, obs2_q[k].first}, {63'd0, tbl2[k].first});
      chk("gap0_cycle", obs2_q[k].cyc, obs2_q[0].cyc + k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/llr_stream_tx.md
# llr_stream_tx

Frame-to-chunk serializer: the transmitting end of the decoder's LLR load interface. Accepts one complete codeword frame of N_V channel LLRs in parallel through a valid/ready handshake. Streams it out as ceil(N_V/N_LLRS) beats of N_LLRS LLRs on the `llr`/`first_data`/`data_valid` bus consumed by the decoder top. Sits between the channel/test-vector source and the decoder, and enforces the inter-frame gap the decoder needs while processing.

## Interface
- WIDTH, 8, bits per LLR
- N_LLRS, 4, LLRs per output beat
- N_V, 31, LLRs (variable nodes) per frame
- GAP_CYCLES, 2, idle cycles forced after the last beat of a frame (covers decoder PROCESS/OFFLOAD)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (compared against `RESET_VAL` from ct.vh)
- frame_in  in  WIDTH*N_V  frame; LLR i at bits [i*WIDTH +: WIDTH]
- frame_valid  in  1  source offers frame_in
- frame_ready  out  1  pending buffer empty; transfer on frame_valid && frame_ready at a rising edge
- hold  in  1  stall request; no beat emitted in a cycle whose preceding edge sampled hold=1
- llr  out  N_LLRS*WIDTH  current beat
- first_data  out  1  high with data_valid on beat 0 only
- data_valid  out  1  llr carries a beat this cycle
- busy  out  1  state != IDLE or pending buffer full

## Operation
- Derived: N_BEATS = (N_V+N_LLRS-1)/N_LLRS; LAST_LLRS = (N_V-1)%N_LLRS+1.
- Two frame registers:
  - pending: written on handshake; pend_valid set.
  - active: shift source for beats.
  - frame_ready = !pend_valid, combinational from the register.
- Beat mapping, k = 0..N_BEATS-2: LLRs N_V-1-k*N_LLRS (MS slot) down to N_V-(k+1)*N_LLRS (LS slot). Last beat: LLRs LAST_LLRS-1..0 in the low LAST_LLRS*WIDTH bits; upper bits driven 0. This is the order the decoder's left-shift loader reassembles.
- FSM states:
  - IDLE: on an edge with pend_valid && !hold, copy pending to active, clear pend_valid, register beat 0 (first_data=1, data_valid=1), beat counter=1, go SEND. If N_BEATS==1, go GAP/IDLE directly.
  - SEND: each edge with !hold registers the next beat (data_valid=1, first_data=0) and increments the counter. On an edge with hold, data_valid=0, first_data=0, llr holds. Emitting beat N_BEATS-1 goes to GAP, with the counter loaded to GAP_CYCLES. If GAP_CYCLES==0, go IDLE.
  - GAP: data_valid=0; counter decrements every edge regardless of hold; go IDLE when it reaches 1.
- A new frame may be accepted into pending during SEND/GAP; a second one is refused until pending drains.
- Reset (any state, mid-frame included):
  - state=IDLE, pend_valid=0, llr=0, first_data=0, data_valid=0, counters=0.
  - In-flight frame dropped; frame_ready=1 the cycle after the reset edge.

## Timing
- All outputs except frame_ready/busy are registered; reset values are 0, frame_ready=1 and busy=0.
- Latency: handshake at edge E0, beat 0 visible after edge E1 (2 edges), given hold=0 and IDLE.
- Beats back-to-back when hold=0: a frame occupies N_BEATS consecutive valid cycles.
- Minimum frame-to-frame spacing: last beat in cycle c, next first_data no earlier than cycle c+GAP_CYCLES+1.
- Simultaneous handshake and pending-to-active transfer on the same edge: not possible (frame_ready=0 while pend_valid); the new frame is accepted on the following edge.
- hold sampled at the same edge as the transfer decision; hold never delays GAP.

## Structure
- N_BEATS, LAST_LLRS and the 3-bit state encodings go into a shared header alongside ct.vh, so the decoder loader and this block agree on chunking.
- One sub-module is natural: llr_beat_mux, a combinational selector of beat k from the active frame, including last-beat zero-fill.
- Counters sized to hold max(N_BEATS, GAP_CYCLES).

## Test plan
Defaults throughout: WIDTH=8, N_LLRS=4, N_V=31; LLR i = i+1.
- Single frame, hold=0 → 8 valid beats: beat 0 llr=0x1F1E1D1C with first_data=1; beat 6 llr=0x07060504; beat 7 llr=0x00030201; then 2 cycles with data_valid=0.
- Two frames offered back-to-back → second accepted during SEND of the first; its first_data appears exactly 3 cycles after the first frame's beat 7.
- hold=1 for 3 cycles during beat 4 → data_valid low for exactly those 3 cycles, llr stable, no beat skipped or repeated, total still 8 valid beats.
- rst=0 for one edge at beat 3 → next cycle all outputs 0, frame_ready=1, busy=0; next frame starts cleanly with first_data.
- Loopback into the decoder top → decoder all_llrs equals frame_in and the decoder reaches PROCESS once per frame.
- N_V=8, N_LLRS=4, GAP_CYCLES=0 → 2 full beats, no zero padding, next frame's first_data in the cycle immediately after.
